system_launch_controller: RTL and testbench
===========================================

# system_launch_controller

- Host-side MMIO initiator for the system control register block.
- A single `start` pulse makes it run the standard launch sequence over the MMIO interface: pulse system reset, enable, execute, poll the halted pseudo-register, then disable.
- Reports completion, timeout or abort, plus the measured run length in cycles.
- Sits between the host command logic (or a test harness) and the system control register device, standing in for a software driver.

## Interface

Parameters:
- `INDEX_WIDTH`, 2: width of `read_index`/`write_index`.
- `DATA_WIDTH`, 32: width of `read_data`/`write_data`.
- `COUNT_WIDTH`, 32: width of `run_cycles`.
- `POLL_INTERVAL`, 4: idle cycles between halted polls (≥0).
- `TIMEOUT_CYCLES`, 1000000: run-length limit; 0 disables the timeout.

Ports:
- `clock` input 1: rising-edge clock.
- `reset` input 1: synchronous, active-high.
- `host_interface` mmio_if.host: drives `read_req`, `read_index`, `write_req`, `write_index`, `write_data`; samples `read_ack`, `read_data`, `write_ack`.
- `start` input 1: begin a launch; sampled only in IDLE.
- `abort` input 1: request early termination while busy.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse on return to IDLE.
- `timed_out` output 1: sticky; last run hit `TIMEOUT_CYCLES`.
- `aborted` output 1: sticky; last run ended by `abort`.
- `run_cycles` output COUNT_WIDTH: cycles from execute-write ack to halted observed; saturates at all-ones.

## Operation

Register map (indices): RESET=0, ENABLE=1, EXECUTE=2, HALTED=3.

State machine: IDLE → W_RST1 (write RESET=1) → W_RST0 (RESET=0) → W_EN (ENABLE=1) → W_EXE (EXECUTE=1) → POLL (read HALTED) → WAIT → POLL ... → W_EXE0 (EXECUTE=0) → W_EN0 (ENABLE=0) → IDLE.
- POLL ack with `read_data[0]`=1 goes to W_EXE0.
- POLL ack with `read_data[0]`=0 goes to WAIT; when `POLL_INTERVAL`=0, it returns directly to POLL.
- WAIT lasts `POLL_INTERVAL` cycles, then returns to POLL.
- Abort path: A_RST1 (RESET=1) → A_RST0 (RESET=0) → IDLE. The device clears enable/execute while reset is high.

Request/handshake rules:
- Requests are Moore outputs of the state. Write states assert `write_req` with fixed index and data; POLL asserts `read_req`, index 3.
- Request, index and data are held stable until the matching ack is sampled high at a clock edge. The state advances on that edge.
- Never assert `read_req` and `write_req` together; never drop a request before its ack.
- Unused data bits are 0. Written values are 0 or 1 zero-extended to DATA_WIDTH.

Counter:
- `run_cycles` clears on the W_EXE ack edge.
- It increments on every edge in POLL/WAIT, saturating, and freezes on the halted POLL ack edge (that edge counts).

Timeout:
- Checked only when not mid-handshake: in WAIT, or on a POLL ack with halted=0.
- If `TIMEOUT_CYCLES`≠0 and `run_cycles` ≥ `TIMEOUT_CYCLES`, set `timed_out` and go to A_RST1.

Abort:
- Latched whenever `busy`; ignored in IDLE.
- A write state or POLL in progress completes its handshake first, then the FSM goes to A_RST1 and sets `aborted`.
- In WAIT, abort goes to A_RST1 on the next edge.
- Abort and timeout on the same edge: set both flags.
- Abort during A_RST1/A_RST0 has no further effect.

Start handling:
- `start` while busy is ignored.
- `start` in IDLE clears `timed_out`, `aborted` and `run_cycles`.

## Timing

- Reset values: state IDLE; `busy`=0, `done`=0, `timed_out`=0, `aborted`=0, `run_cycles`=0; all requests 0, indices 0, `write_data`=0.
- Reset mid-sequence returns to IDLE on the same edge, with requests dropped next cycle. The device is not cleaned up.
- `start` sampled at edge t: W_RST1 request visible in cycle t+1.
- With a zero-latency (combinational ack) device, each MMIO access takes exactly one cycle.
  - Launch writes occupy cycles t+1..t+4; first POLL at t+5.
  - Shutdown writes take 2 cycles; `done` pulses in the first IDLE cycle.
- Halted seen on the first poll with a zero-latency device gives `run_cycles`=1.
- Each extra ack-latency cycle stretches only its own state.

## Test plan

- Zero-latency device, halted rises before first poll, `POLL_INTERVAL`=4 → write sequence (0,1),(0,0),(1,1),(2,1), one read of index 3, then writes (2,0),(1,0); `run_cycles`=1; `done` at t+8; flags 0.
- Halted rises 20 cycles after execute → polls every 5 cycles; `run_cycles` equals the ack edge of the first poll reading 1; `timed_out`=0.
- `TIMEOUT_CYCLES`=50, halted never set → `timed_out`=1, writes (0,1),(0,0) after the first check with `run_cycles`≥50, then `done`.
- Device acks 3 cycles late → request, index and data stable for 4 cycles per access; `abort` raised mid-write finishes that write, then takes the abort path; `aborted`=1.
- `start` pulsed while busy → no effect; reset asserted during POLL → next cycle all outputs at reset values.
- `TIMEOUT_CYCLES`=0 with `COUNT_WIDTH`=4, halted after 30 cycles → `run_cycles` saturates at 15, no timeout.

Source files
------------

// File: rtl/system_launch_controller_if.sv
`default_nettype none
// ============================================================================
// mmio_if : MMIO request/ack bundle between host initiator and register device
// Rev 1.0
// ============================================================================
interface mmio_if #(
   parameter int INDEX_WIDTH = 2,
   parameter int DATA_WIDTH  = 32
) ();
   logic                   read_req;
   logic [INDEX_WIDTH-1:0] read_index;
   logic                   read_ack;
   logic [DATA_WIDTH-1:0]  read_data;
   logic                   write_req;
   logic [INDEX_WIDTH-1:0] write_index;
   logic [DATA_WIDTH-1:0]  write_data;
   logic                   write_ack;

   modport host (
      output read_req, read_index, write_req, write_index, write_data,
      input  read_ack, read_data, write_ack
   );

   modport device (
      input  read_req, read_index, write_req, write_index, write_data,
      output read_ack, read_data, write_ack
   );
endinterface
`default_nettype wire

// File: rtl/system_launch_controller.sv
`default_nettype none
// ============================================================================
// system_launch_controller : MMIO launch sequencer (reset, enable, execute,
// poll halted, disable) with timeout, abort and run-length measurement
// Rev 1.0
// ============================================================================
module system_launch_controller #(
   parameter int INDEX_WIDTH    = 2,
   parameter int DATA_WIDTH     = 32,
   parameter int COUNT_WIDTH    = 32,
   parameter int POLL_INTERVAL  = 4,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                   clock,
   input  logic                   reset,
   mmio_if.host                   host_interface,
   input  logic                   start,
   input  logic                   abort,
   output logic                   busy,
   output logic                   done,
   output logic                   timed_out,
   output logic                   aborted,
   output logic [COUNT_WIDTH-1:0] run_cycles
);
   localparam logic [INDEX_WIDTH-1:0] c_IDX_RESET   = INDEX_WIDTH'(0);
   localparam logic [INDEX_WIDTH-1:0] c_IDX_ENABLE  = INDEX_WIDTH'(1);
   localparam logic [INDEX_WIDTH-1:0] c_IDX_EXECUTE = INDEX_WIDTH'(2);
   localparam logic [INDEX_WIDTH-1:0] c_IDX_HALTED  = INDEX_WIDTH'(3);
   localparam logic [DATA_WIDTH-1:0]  c_ONE         = DATA_WIDTH'(1);
   localparam int                     WAIT_W        = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
   localparam int                     WAIT_LAST     = (POLL_INTERVAL > 0) ? POLL_INTERVAL - 1 : 0;
   localparam logic [63:0]            TIMEOUT_LIMIT = 64'(TIMEOUT_CYCLES);

   typedef enum logic [3:0] {
      IDLE, W_RST1, W_RST0, W_EN, W_EXE, POLL, WAIT, W_EXE0, W_EN0, A_RST1, A_RST0
   } state_t;

   state_t                 r_state;
   state_t                 w_next;
   logic                   r_busy;
   logic                   r_done;
   logic                   r_timed_out;
   logic                   r_aborted;
   logic                   r_abort_pend;
   logic [COUNT_WIDTH-1:0] r_run_cycles;
   logic [WAIT_W-1:0]      r_wait_cnt;
   logic                   r_read_req;
   logic                   r_write_req;
   logic [INDEX_WIDTH-1:0] r_read_index;
   logic [INDEX_WIDTH-1:0] r_write_index;
   logic [DATA_WIDTH-1:0]  r_write_data;

   logic                   w_abort_now;
   logic                   w_halted;
   logic                   w_timeout_hit;
   logic                   w_set_aborted;
   logic                   w_set_timeout;
   logic [COUNT_WIDTH-1:0] w_run_inc;
   logic                   w_unused_read_bits;

   assign host_interface.read_req    = r_read_req;
   assign host_interface.read_index  = r_read_index;
   assign host_interface.write_req   = r_write_req;
   assign host_interface.write_index = r_write_index;
   assign host_interface.write_data  = r_write_data;

   assign busy       = r_busy;
   assign done       = r_done;
   assign timed_out  = r_timed_out;
   assign aborted    = r_aborted;
   assign run_cycles = r_run_cycles;

   assign w_halted           = host_interface.read_data[0];
   assign w_unused_read_bits = ^host_interface.read_data[DATA_WIDTH-1:1];
   assign w_abort_now        = r_abort_pend | abort;
   assign w_run_inc          = (&r_run_cycles) ? r_run_cycles : r_run_cycles + COUNT_WIDTH'(1);
   assign w_timeout_hit      = (TIMEOUT_CYCLES != 0) && (64'(r_run_cycles) >= TIMEOUT_LIMIT);

   function automatic state_t write_successor(input state_t s);
      state_t nxt;
      case (s)
         W_RST1:  nxt = W_RST0;
         W_RST0:  nxt = W_EN;
         W_EN:    nxt = W_EXE;
         W_EXE:   nxt = POLL;
         W_EXE0:  nxt = W_EN0;
         default: nxt = IDLE;
      endcase
      return nxt;
   endfunction

   always_comb begin
      w_next        = r_state;
      w_set_aborted = 1'b0;
      w_set_timeout = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) w_next = W_RST1;
         end
         W_RST1, W_RST0, W_EN, W_EXE, W_EXE0, W_EN0: begin
            if (host_interface.write_ack) begin
               if (w_abort_now) begin
                  w_next        = A_RST1;
                  w_set_aborted = 1'b1;
               end else begin
                  w_next = write_successor(r_state);
               end
            end
         end
         POLL: begin
            if (host_interface.read_ack) begin
               // a pending abort still wins over a halted result
               w_set_timeout = !w_halted && w_timeout_hit;
               w_set_aborted = w_abort_now;
               if (w_abort_now || w_set_timeout) w_next = A_RST1;
               else if (w_halted)                w_next = W_EXE0;
               else if (POLL_INTERVAL == 0)      w_next = POLL;
               else                              w_next = WAIT;
            end
         end
         WAIT: begin
            w_set_timeout = w_timeout_hit;
            w_set_aborted = w_abort_now;
            if (w_abort_now || w_timeout_hit)                w_next = A_RST1;
            else if (r_wait_cnt == WAIT_W'(WAIT_LAST))       w_next = POLL;
         end
         A_RST1: begin
            if (host_interface.write_ack) w_next = A_RST0;
         end
         A_RST0: begin
            if (host_interface.write_ack) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state       <= IDLE;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_timed_out   <= 1'b0;
         r_aborted     <= 1'b0;
         r_abort_pend  <= 1'b0;
         r_run_cycles  <= '0;
         r_wait_cnt    <= '0;
         r_read_req    <= 1'b0;
         r_write_req   <= 1'b0;
         r_read_index  <= '0;
         r_write_index <= '0;
         r_write_data  <= '0;
      end else begin
         r_state <= w_next;
         r_busy  <= (w_next != IDLE);
         r_done  <= (r_state != IDLE) && (w_next == IDLE);

         if (abort && r_state != IDLE && r_state != A_RST1 && r_state != A_RST0)
            r_abort_pend <= 1'b1;
         if (w_next == A_RST1 || w_next == IDLE)
            r_abort_pend <= 1'b0;

         if (r_state == IDLE && start) begin
            r_timed_out  <= 1'b0;
            r_aborted    <= 1'b0;
            r_run_cycles <= '0;
         end
         if (w_set_timeout) r_timed_out <= 1'b1;
         if (w_set_aborted) r_aborted   <= 1'b1;

         if (r_state == W_EXE && host_interface.write_ack)
            r_run_cycles <= '0;
         else if (r_state == POLL || r_state == WAIT)
            r_run_cycles <= w_run_inc;

         r_wait_cnt <= (r_state == WAIT) ? r_wait_cnt + WAIT_W'(1) : '0;

         // requests are decoded from the next state so they stay put until acked
         r_read_req    <= 1'b0;
         r_write_req   <= 1'b0;
         r_read_index  <= '0;
         r_write_index <= '0;
         r_write_data  <= '0;
         case (w_next)
            W_RST1, A_RST1: begin
               r_write_req   <= 1'b1;
               r_write_index <= c_IDX_RESET;
               r_write_data  <= c_ONE;
            end
            W_RST0, A_RST0: begin
               r_write_req   <= 1'b1;
               r_write_index <= c_IDX_RESET;
            end
            W_EN: begin
               r_write_req   <= 1'b1;
               r_write_index <= c_IDX_ENABLE;
               r_write_data  <= c_ONE;
            end
            W_EXE: begin
               r_write_req   <= 1'b1;
               r_write_index <= c_IDX_EXECUTE;
               r_write_data  <= c_ONE;
            end
            W_EXE0: begin
               r_write_req   <= 1'b1;
               r_write_index <= c_IDX_EXECUTE;
            end
            W_EN0: begin
               r_write_req   <= 1'b1;
               r_write_index <= c_IDX_ENABLE;
            end
            POLL: begin
               r_read_req   <= 1'b1;
               r_read_index <= c_IDX_HALTED;
            end
            default: ;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_system_launch_controller.sv
`default_nettype none
`timescale 1ns/1ps
// tb_system_launch_controller : directed vectors against two controller
// instances, each driving a behavioural register device.
module tb_system_launch_controller;
   logic        clock = 1'b0;
   always #5 clock = ~clock;

   logic        reset;
   logic        start_a, abort_a, start_b, abort_b;
   logic        busy_a, done_a, to_a, ab_a;
   logic        busy_b, done_b, to_b, ab_b;
   logic [31:0] run_a;
   logic [3:0]  run_b;

   mmio_if #(.INDEX_WIDTH(2), .DATA_WIDTH(32)) mif_a ();
   mmio_if #(.INDEX_WIDTH(2), .DATA_WIDTH(32)) mif_b ();

   system_launch_controller #(
      .INDEX_WIDTH(2), .DATA_WIDTH(32), .COUNT_WIDTH(32),
      .POLL_INTERVAL(4), .TIMEOUT_CYCLES(50)
   ) dut_a (
      .clock(clock), .reset(reset), .host_interface(mif_a),
      .start(start_a), .abort(abort_a), .busy(busy_a), .done(done_a),
      .timed_out(to_a), .aborted(ab_a), .run_cycles(run_a)
   );

   system_launch_controller #(
      .INDEX_WIDTH(2), .DATA_WIDTH(32), .COUNT_WIDTH(4),
      .POLL_INTERVAL(4), .TIMEOUT_CYCLES(0)
   ) dut_b (
      .clock(clock), .reset(reset), .host_interface(mif_b),
      .start(start_b), .abort(abort_b), .busy(busy_b), .done(done_b),
      .timed_out(to_b), .aborted(ab_b), .run_cycles(run_b)
   );

   // ---------------- device model A: programmable ack latency ----------------
   int          lat = 0;
   int          halt_delay = 0;
   int          lat_cnt = 0;
   int          d_age = 0;
   int          wr_total = 0;
   int          rd_total = 0;
   int          prot_err = 0;
   logic        d_rst = 1'b0, d_en = 1'b0, d_exe = 1'b0;
   logic [31:0] wr_log = '0;
   logic        pend = 1'b0;
   logic [37:0] pend_sig = '0;
   logic [37:0] cur_sig;

   assign cur_sig = {mif_a.read_req, mif_a.write_req, mif_a.read_index,
                     mif_a.write_index, mif_a.write_data};

   always_comb begin
      mif_a.write_ack = mif_a.write_req && (lat_cnt == lat);
      mif_a.read_ack  = mif_a.read_req && (lat_cnt == lat);
      mif_a.read_data = {31'b0, d_exe && (d_age >= halt_delay)};
   end

   always @(posedge clock) begin
      if (reset) begin
         lat_cnt <= 0;
         d_rst   <= 1'b0;
         d_en    <= 1'b0;
         d_exe   <= 1'b0;
         d_age   <= 0;
         pend    <= 1'b0;
      end else begin
         prot_err <= prot_err
                     + int'(pend && (cur_sig != pend_sig))
                     + int'(mif_a.read_req && mif_a.write_req)
                     + int'(mif_a.write_req && (mif_a.write_data[31:1] != 31'b0))
                     + int'(mif_a.read_req && (mif_a.read_index != 2'd3));
         pend     <= (mif_a.read_req || mif_a.write_req) && !(mif_a.read_ack || mif_a.write_ack);
         pend_sig <= cur_sig;
         if ((mif_a.read_req || mif_a.write_req) && !(mif_a.read_ack || mif_a.write_ack))
            lat_cnt <= lat_cnt + 1;
         else
            lat_cnt <= 0;
         if (d_age < 100000) d_age <= d_age + 1;
         if (mif_a.read_req && mif_a.read_ack) rd_total <= rd_total + 1;
         if (mif_a.write_req && mif_a.write_ack) begin
            wr_total <= wr_total + 1;
            wr_log   <= {wr_log[27:0], mif_a.write_index, mif_a.write_data[1:0]};
            case (mif_a.write_index)
               2'd0: begin
                  d_rst <= mif_a.write_data[0];
                  if (mif_a.write_data[0]) begin
                     d_en  <= 1'b0;
                     d_exe <= 1'b0;
                  end
               end
               2'd1: d_en <= mif_a.write_data[0] && !d_rst;
               2'd2: begin
                  d_exe <= mif_a.write_data[0] && !d_rst;
                  d_age <= 0;
               end
               default: ;
            endcase
         end
      end
   end

   // ---------------- device model B: zero latency, halts 30 cycles after execute
   logic exe_b = 1'b0;
   int   age_b = 0;
   assign mif_b.write_ack = mif_b.write_req;
   assign mif_b.read_ack  = mif_b.read_req;
   assign mif_b.read_data = {31'b0, exe_b && (age_b >= 30)};

   always @(posedge clock) begin
      if (reset) begin
         exe_b <= 1'b0;
         age_b <= 0;
      end else begin
         if (age_b < 100000) age_b <= age_b + 1;
         if (mif_b.write_req && mif_b.write_index == 2'd2) begin
            exe_b <= mif_b.write_data[0];
            age_b <= 0;
         end
      end
   end

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   typedef struct {
      int          lat;
      int          halt_delay;
      int          abort_cyc;
      int          start_cyc;
      int          exp_done;
      int          exp_run;
      int          exp_to;
      int          exp_ab;
      int          exp_nwr;
      logic [31:0] exp_wr;
      int          exp_nrd;
   } vec_t;

   localparam int NV = 7;
   vec_t vec [NV];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int          n;
      bit          got;
      int          wr_snap, rd_snap, pe_snap;
      logic [31:0] mask;

      reset = 1'b1; start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;

      // nibble per write: {index[1:0], data[1:0]}, oldest write most significant
      vec[0] = '{lat:0, halt_delay:0,      abort_cyc:0,  start_cyc:0,  exp_done:8,  exp_run:1,  exp_to:0, exp_ab:0, exp_nwr:6, exp_wr:32'h00105984, exp_nrd:1};
      vec[1] = '{lat:0, halt_delay:20,     abort_cyc:0,  start_cyc:12, exp_done:28, exp_run:21, exp_to:0, exp_ab:0, exp_nwr:6, exp_wr:32'h00105984, exp_nrd:5};
      vec[2] = '{lat:0, halt_delay:100000, abort_cyc:0,  start_cyc:0,  exp_done:58, exp_run:51, exp_to:1, exp_ab:0, exp_nwr:6, exp_wr:32'h00105910, exp_nrd:11};
      vec[3] = '{lat:3, halt_delay:0,      abort_cyc:10, start_cyc:0,  exp_done:21, exp_run:0,  exp_to:0, exp_ab:1, exp_nwr:5, exp_wr:32'h00010510, exp_nrd:0};
      vec[4] = '{lat:1, halt_delay:7,      abort_cyc:0,  start_cyc:0,  exp_done:21, exp_run:8,  exp_to:0, exp_ab:0, exp_nwr:6, exp_wr:32'h00105984, exp_nrd:2};
      vec[5] = '{lat:0, halt_delay:100000, abort_cyc:7,  start_cyc:0,  exp_done:10, exp_run:3,  exp_to:0, exp_ab:1, exp_nwr:6, exp_wr:32'h00105910, exp_nrd:1};
      vec[6] = '{lat:0, halt_delay:100000, abort_cyc:55, start_cyc:0,  exp_done:58, exp_run:51, exp_to:1, exp_ab:1, exp_nwr:6, exp_wr:32'h00105910, exp_nrd:11};

      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst_busy",        busy_a, 0);
      check("rst_done",        done_a, 0);
      check("rst_timed_out",   to_a, 0);
      check("rst_aborted",     ab_a, 0);
      check("rst_run_cycles",  run_a, 0);
      check("rst_read_req",    mif_a.read_req, 0);
      check("rst_write_req",   mif_a.write_req, 0);
      check("rst_read_index",  mif_a.read_index, 0);
      check("rst_write_index", mif_a.write_index, 0);
      check("rst_write_data",  mif_a.write_data, 0);
      check("rst_busy_b",      busy_b, 0);
      reset = 1'b0;

      for (int s = 0; s < NV; s++) begin
         lat        = vec[s].lat;
         halt_delay = vec[s].halt_delay;
         wr_snap    = wr_total;
         rd_snap    = rd_total;
         pe_snap    = prot_err;
         @(negedge clock);
         start_a = 1'b1;
         @(posedge clock);
         #1 start_a = 1'b0;
         n   = 1;
         got = 1'b0;
         while (n < 200 && !got) begin
            @(negedge clock);
            abort_a = (n == vec[s].abort_cyc);
            start_a = (n == vec[s].start_cyc);
            if (done_a) got = 1'b1;
            else begin
               @(posedge clock);
               n++;
            end
         end
         abort_a = 1'b0;
         start_a = 1'b0;
         mask = 32'((64'd1 << (4 * vec[s].exp_nwr)) - 64'd1);
         check($sformatf("v%0d_done_cycle", s), got ? n : -1, vec[s].exp_done);
         check($sformatf("v%0d_run_cycles", s), run_a, vec[s].exp_run);
         check($sformatf("v%0d_timed_out", s),  to_a, vec[s].exp_to);
         check($sformatf("v%0d_aborted", s),    ab_a, vec[s].exp_ab);
         check($sformatf("v%0d_num_writes", s), wr_total - wr_snap, vec[s].exp_nwr);
         check($sformatf("v%0d_write_seq", s),  wr_log & mask, vec[s].exp_wr);
         check($sformatf("v%0d_num_reads", s),  rd_total - rd_snap, vec[s].exp_nrd);
         check($sformatf("v%0d_protocol", s),   prot_err - pe_snap, 0);
         @(negedge clock);
         check($sformatf("v%0d_done_pulse", s), done_a, 0);
         check($sformatf("v%0d_idle_busy", s),  busy_a, 0);
      end

      // reset while polling: everything back to reset values one cycle later
      lat = 0;
      halt_delay = 100000;
      @(negedge clock);
      start_a = 1'b1;
      @(posedge clock);
      #1 start_a = 1'b0;
      n = 0;
      got = 1'b0;
      while (n < 40 && !got) begin
         @(negedge clock);
         if (mif_a.read_req && run_a >= 10) got = 1'b1;
         n++;
      end
      check("poll_reached", got, 1);
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      check("midrst_busy",       busy_a, 0);
      check("midrst_read_req",   mif_a.read_req, 0);
      check("midrst_read_index", mif_a.read_index, 0);
      check("midrst_write_req",  mif_a.write_req, 0);
      check("midrst_run_cycles", run_a, 0);
      check("midrst_done",       done_a, 0);
      reset = 1'b0;

      // narrow counter with no timeout: saturates, never times out
      @(negedge clock);
      start_b = 1'b1;
      @(posedge clock);
      #1 start_b = 1'b0;
      n   = 1;
      got = 1'b0;
      while (n < 100 && !got) begin
         @(negedge clock);
         if (done_b) got = 1'b1;
         else begin
            @(posedge clock);
            n++;
         end
      end
      check("sat_done_cycle", got ? n : -1, 38);
      check("sat_run_cycles", run_b, 15);
      check("sat_timed_out",  to_b, 0);
      check("sat_aborted",    ab_b, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
